// File: rtl/cpu_pkg.sv
// Shared word width and single-entry slot state encoding for valid/ready buffer stages.
package cpu_pkg;

  localparam int CPU_WORD_W          = 32;
  localparam int DEMUX_WIDTH_DEFAULT = CPU_WORD_W;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  // A slot can take a new word if it is empty or its current word leaves this cycle.
  function automatic logic slot_has_space(input slot_state_t st, input logic drain);
    return (st == SLOT_EMPTY) || drain;
  endfunction

endpackage

// File: rtl/stream_demux_if.sv
// Upstream and per-channel downstream signals of stream_demux.
// The in_bcast wire exists only when STREAM_DEMUX_BROADCAST_EN is defined.
interface stream_demux_if
  import cpu_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH_DEFAULT,
  parameter int NOUT  = 4
) ();

  localparam int SELW = $clog2(NOUT);

  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_data;
  logic [SELW-1:0]       in_sel;
  logic [NOUT-1:0]       out_valid;
  logic [NOUT-1:0]       out_ready;
  logic [NOUT*WIDTH-1:0] out_data;
  logic                  sel_err;
`ifdef STREAM_DEMUX_BROADCAST_EN
  logic                  in_bcast;

  modport master (
    output in_valid, in_data, in_sel, in_bcast, out_ready,
    input  in_ready, out_valid, out_data, sel_err
  );
  modport slave (
    input  in_valid, in_data, in_sel, in_bcast, out_ready,
    output in_ready, out_valid, out_data, sel_err
  );
`else
  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data, sel_err
  );
  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data, sel_err
  );
`endif

endinterface

// File: rtl/demux_slot.sv
// One-entry output register: loads a word, holds it stable until the consumer takes it.
module demux_slot
  import cpu_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_out_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_space
);

  slot_state_t      r_state;
  slot_state_t      w_state_nxt;
  logic [WIDTH-1:0] r_data;
  logic             w_drain;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SLOT_EMPTY;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (i_load) r_data <= i_data;
    end
  end

  assign w_drain = (r_state == SLOT_FULL) && i_out_ready;

  // A drain and a load on the same edge keep the slot full with the new word.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SLOT_EMPTY: if (i_load) w_state_nxt = SLOT_FULL;
      SLOT_FULL:  if (w_drain && !i_load) w_state_nxt = SLOT_EMPTY;
      default:    w_state_nxt = SLOT_EMPTY;
    endcase
  end

  always_comb begin
    o_valid = (r_state == SLOT_FULL);
    o_space = slot_has_space(r_state, w_drain);
    o_data  = r_data;
  end

endmodule

// File: rtl/stream_demux.sv
// Routes one valid/ready word stream to NOUT one-entry output slots, one cycle latency.
// Out-of-range selects are dropped and flagged; STREAM_DEMUX_BROADCAST_EN adds broadcast.
module stream_demux
  import cpu_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH_DEFAULT,
  parameter int NOUT  = 4
) (
  input  logic           clk,
  input  logic           rst,
  stream_demux_if.slave  bus
);

  logic [NOUT-1:0]  w_dec;
  logic [NOUT-1:0]  w_space;
  logic [NOUT-1:0]  w_load;
  logic [NOUT-1:0]  w_valid;
  logic [WIDTH-1:0] w_data [NOUT];
  logic             w_sel_ok;
  logic             w_bcast;
  logic             w_in_ready;
  logic             w_accept;
  logic             r_sel_err;

`ifdef STREAM_DEMUX_BROADCAST_EN
  assign w_bcast = bus.in_bcast;
`else
  assign w_bcast = 1'b0;
`endif

  // A select beyond the last channel matches no decode bit, which is how it is detected.
  always_comb begin
    w_dec = '0;
    for (int k = 0; k < NOUT; k++) begin
      w_dec[k] = (int'(bus.in_sel) == k);
    end
  end

  assign w_sel_ok = |w_dec;

  always_comb begin
    if (w_bcast)       w_in_ready = &w_space;
    else if (w_sel_ok) w_in_ready = |(w_space & w_dec);
    else               w_in_ready = 1'b1;
  end

  assign w_accept = bus.in_valid && w_in_ready;
  assign w_load   = !w_accept ? '0 : (w_bcast ? {NOUT{1'b1}} : w_dec);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel_err <= 1'b0;
    end else if (w_accept && !w_bcast && !w_sel_ok) begin
      r_sel_err <= 1'b1;
    end
  end

  for (genvar k = 0; k < NOUT; k++) begin : g_slot
    demux_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk         (clk),
      .rst         (rst),
      .i_load      (w_load[k]),
      .i_data      (bus.in_data),
      .i_out_ready (bus.out_ready[k]),
      .o_valid     (w_valid[k]),
      .o_data      (w_data[k]),
      .o_space     (w_space[k])
    );
  end

  always_comb begin
    bus.out_data = '0;
    for (int k = 0; k < NOUT; k++) begin
      bus.out_data[k*WIDTH +: WIDTH] = w_data[k];
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_valid;
  assign bus.sel_err   = r_sel_err;

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux with three channels so that in_sel=3 is an out-of-range select.
module tb_stream_demux;

  localparam int W  = 32;
  localparam int N  = 3;
  localparam int SW = $clog2(N);

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  stream_demux_if #(.WIDTH(W), .NOUT(N)) bus ();

  stream_demux #(.WIDTH(W), .NOUT(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference: which slots hold a word, what each slot shows, and the sticky error.
  bit           m_full [N];
  logic [W-1:0] m_data [N];
  bit           m_err;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic bit model_ready(input int s, input logic [N-1:0] ordy, input bit bc);
    if (bc) begin
      for (int k = 0; k < N; k++) if (m_full[k] && !ordy[k]) return 1'b0;
      return 1'b1;
    end
    if (s >= N) return 1'b1;
    return !m_full[s] || ordy[s];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_full[k] = 1'b0;
      m_data[k] = '0;
    end
    m_err = 1'b0;
  endtask

  task automatic drive(input logic v, input int s, input logic [W-1:0] d,
                       input logic [N-1:0] ordy, input bit bc);
    bus.in_valid  = v;
    bus.in_sel    = SW'(s);
    bus.in_data   = d;
    bus.out_ready = ordy;
`ifdef STREAM_DEMUX_BROADCAST_EN
    bus.in_bcast  = bc;
`endif
  endtask

  task automatic check_outputs(input string pfx);
    logic [N-1:0] ev;
    for (int k = 0; k < N; k++) ev[k] = m_full[k];
    check({pfx, "_vld"}, bus.out_valid, ev);
    for (int k = 0; k < N; k++)
      check($sformatf("%s_dat%0d", pfx, k), bus.out_data[k*W +: W], m_data[k]);
    check({pfx, "_err"}, bus.sel_err, m_err);
  endtask

  // One clock: drive, check in_ready, advance the model across the edge, check outputs.
  task automatic cycle(input logic v, input int s, input logic [W-1:0] d,
                       input logic [N-1:0] ordy, input bit bc, output bit acc);
    bit er;
    @(negedge clk);
    drive(v, s, d, ordy, bc);
    #1;
    er = model_ready(s, ordy, bc);
    check("in_ready", bus.in_ready, er);
    acc = v && er;
    @(posedge clk);
    for (int k = 0; k < N; k++) if (m_full[k] && ordy[k]) m_full[k] = 1'b0;
    if (acc) begin
      if (bc) begin
        for (int k = 0; k < N; k++) begin
          m_full[k] = 1'b1;
          m_data[k] = d;
        end
      end else if (s < N) begin
        m_full[s] = 1'b1;
        m_data[s] = d;
      end else begin
        m_err = 1'b1;
      end
    end
    #1;
    check_outputs("cyc");
  endtask

  task automatic do_reset(input logic v);
    @(negedge clk);
    rst = 1'b1;
    drive(v, 0, 32'h77, '1, 1'b0);
    @(posedge clk);
    model_reset();
    #1;
    check_outputs("rst");
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 0, '0, '0, 1'b0);
    #1;
    check("rst_rdy", bus.in_ready, 1);
  endtask

  // Looks at in_ready without letting a clock edge pass under these inputs.
  task automatic probe(input string tag, input int s, input logic [N-1:0] ordy, input bit exp);
    drive(1'b0, s, '0, ordy, 1'b0);
    #1;
    check(tag, bus.in_ready, exp);
  endtask

  initial begin
    bit acc;
    rst = 1'b1;
    drive(1'b0, 0, '0, '0, 1'b0);
    model_reset();
    do_reset(1'b0);

    cycle(1'b1, 2, 32'd10, 3'b000, 1'b0, acc);
    check("t1_vld", bus.out_valid, 3'b100);
    check("t1_dat2", bus.out_data[2*W +: W], 10);
    probe("t1_rdy_s2", 2, 3'b000, 1'b0);
    probe("t1_rdy_s0", 0, 3'b000, 1'b1);

    cycle(1'b1, 1, 32'd19, 3'b000, 1'b0, acc);
    cycle(1'b1, 1, 32'd20, 3'b010, 1'b0, acc);
    check("t2_vld1", bus.out_valid[1], 1);
    check("t2_dat1", bus.out_data[W +: W], 20);

    for (int i = 1; i <= 3; i++) begin
      cycle(1'b1, 0, W'(i), 3'b001, 1'b0, acc);
      check($sformatf("t3_dat0_%0d", i), bus.out_data[0 +: W], i);
    end

    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 0, W'(100 + i), 3'b011, 1'b0, acc);
      check("t4_dat0", bus.out_data[0 +: W], 100 + i);
      check("t4_vld2", bus.out_valid[2], 1);
      check("t4_dat2", bus.out_data[2*W +: W], 10);
    end

    probe("t5_rdy", 3, 3'b000, 1'b1);
    cycle(1'b1, 3, 32'd99, 3'b000, 1'b0, acc);
    check("t5_err", bus.sel_err, 1);
    cycle(1'b0, 0, '0, 3'b111, 1'b0, acc);
    check("t5_err_hold", bus.sel_err, 1);
    do_reset(1'b0);
    check("t5_err_rst", bus.sel_err, 0);

    cycle(1'b1, 0, 32'd5, 3'b000, 1'b0, acc);
    cycle(1'b1, 2, 32'd6, 3'b000, 1'b0, acc);
    do_reset(1'b1);
    check("t6_vld", bus.out_valid, 0);
`ifdef STREAM_DEMUX_BROADCAST_EN
    cycle(1'b1, 3, 32'd55, 3'b000, 1'b1, acc);
    check("t6_bc_vld", bus.out_valid, 3'b111);
    check("t6_bc_err", bus.sel_err, 0);
    for (int k = 0; k < N; k++)
      check($sformatf("t6_bc_dat%0d", k), bus.out_data[k*W +: W], 55);
`endif

    begin
      logic         v;
      int           s;
      logic [W-1:0] d;
      logic [N-1:0] o;
      bit           bc;
      bit           hold;
      v = 1'b0; s = 0; d = '0; bc = 1'b0; hold = 1'b0;
      for (int i = 0; i < 1500; i++) begin
        if ($urandom_range(0, 199) == 0) begin
          do_reset(1'($urandom_range(0, 1)));
          hold = 1'b0;
        end
        if (!hold) begin
          v = ($urandom_range(0, 3) != 0);
          s = ($urandom_range(0, 7) == 0) ? 3 : int'($urandom_range(0, N-1));
          d = $urandom;
`ifdef STREAM_DEMUX_BROADCAST_EN
          bc = ($urandom_range(0, 7) == 0);
`endif
        end
        o = N'($urandom);
        cycle(v, s, d, o, bc, acc);
        hold = v && !acc;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- Routes one valid/ready stream of W-bit words to one of N destination channels, selected per word by in_sel. It performs the opposite direction of the datapath's Multiplexer2 trees.
- Each destination has a one-entry registered output slot, so downstream stalls on one channel do not block words bound for other channels.
- Sits between the execute/result stage and the per-unit consumers (writeback, store buffer, branch unit).

Parameters:
- WIDTH, 32, data word width in bits.
- NOUT, 4, number of destination channels, 2..16.
- SELW, $clog2(NOUT), in_sel width. Derived; not overridden.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  upstream word present.
- in_ready  output  1  block accepts the word this cycle.
- in_data  input  WIDTH  payload.
- in_sel  input  SELW  destination index.
- out_valid  output  NOUT  per-channel slot full.
- out_ready  input  NOUT  per-channel consumer accepts.
- out_data  output  NOUT*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- sel_err  output  1  sticky flag: a word with in_sel >= NOUT was seen.

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0 on all channels, out_data=0, sel_err=0. in_ready is combinational and evaluates to 1 after reset. Reset mid-transfer discards all slot contents; no partial words survive.
- Transfer rule: a word transfers on an edge where in_valid && in_ready. A channel k drains on an edge where out_valid[k] && out_ready[k].
- Latency: a word accepted at edge t appears at out_valid[sel]/out_data[sel] after edge t, i.e. one cycle. Bandwidth is one word per cycle.
- in_ready is combinational from the current state, in_sel and out_ready:
  - If in_sel < NOUT: in_ready = !out_valid[in_sel] || out_ready[in_sel]. Pass-through on the same edge is allowed: slot k drains and refills in one cycle.
  - If in_sel >= NOUT: in_ready = 1. The word is dropped and sel_err is set at that edge. sel_err is cleared only by rst.
  - in_ready does not depend on in_valid.
- Per-slot state machine, two states:
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on drain with no accept.
  - FULL -> FULL on simultaneous drain+accept; the new data is loaded.
  - FULL holds out_data stable while out_ready[k]=0.
- Other channels drain independently on every edge, regardless of which channel in_sel targets.
- Ordering is preserved per channel. There is no ordering guarantee across channels.
- out_data[k] holds its last value when EMPTY. It is not cleared except by reset.
- Upstream is required to hold in_data/in_sel stable while in_valid && !in_ready. The block does not check this.

Optional Feature:
- Macro: STREAM_DEMUX_BROADCAST_EN.
- Defined: adds input port in_bcast (1 bit).
  - When in_bcast=1, in_sel is ignored.
  - in_ready = AND over all k of (!out_valid[k] || out_ready[k]).
  - On accept, every slot loads in_data and becomes FULL.
  - sel_err is never set by a broadcast word.
- Undefined: the in_bcast port does not exist and the behaviour is exactly as above.

Decomposition:
- Shared package cpu_pkg: word-width constant, the WIDTH default, and a typedef for the slot state enum (SLOT_EMPTY, SLOT_FULL). Reused by other valid/ready buffers.
- One sub-module demux_slot: a single-entry register with load, drain, valid and data.
  - stream_demux instantiates NOUT of them via a generate loop.
  - The top level holds only the select decode, the in_ready logic and sel_err.

Test Plan:
1. Reset, then in_valid=1, in_sel=2, in_data=10, all out_ready=0 -> after 1 edge out_valid=4'b0100, out_data[2]=10; in_ready then 0 for sel=2 and 1 for sel=0.
2. Slot 1 full, out_ready[1]=1, new word 20 with sel=1 on the same edge -> accepted; next cycle out_valid[1]=1, out_data[1]=20 (drain+refill).
3. Back-to-back words 1,2,3 to sel=0 with out_ready[0]=1 every cycle -> out_data[0] shows 1,2,3 on consecutive cycles; in_ready stays 1 throughout.
4. Channel 3 stalled full; words to sel=0 -> still accepted and delivered; out_data[3] holds constant throughout.
5. NOUT=3, in_sel=3, data 99 -> in_ready=1, word dropped, sel_err=1 and it persists; rst -> sel_err=0.
6. Reset asserted while slots 0 and 2 are full -> next cycle all out_valid=0; with STREAM_DEMUX_BROADCAST_EN defined, broadcast word 55 -> all slots FULL with 55.
